// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : cpu_pkg                                                |
// | Shared defaults, the register-address type and the constants     |
// | used by the CPU register file and its pending-write scoreboard.  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package cpu_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int NUM_REGS_DEF = 8;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  // Register address for the default-sized register file
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // Index of the hard-wired zero register and the value loaded on reset
  localparam int REG_ZERO  = 0;
  localparam int RESET_VAL = 0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : reg_scoreboard                                         |
// | Pending-write scoreboard: one bit per register, set by a reserve |
// | and cleared by the matching write (reserve wins on a same-edge   |
// | collision). Also provides the pending lookup for both read ports.|
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int ZERO_REG0 = 0,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                write_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic                reserve_i,
  input  logic [ADDR_W-1:0]   rsv_addr_i,
  input  logic [ADDR_W-1:0]   rd1_addr_i,
  input  logic [ADDR_W-1:0]   rd2_addr_i,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                rd1_pending_o,
  output logic                rd2_pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                rsv_blocked;

  // Register 0 can never become pending when it is hard-wired to zero
  assign rsv_blocked = (ZERO_REG0 != 0) && (rsv_addr_i == ADDR_W'(REG_ZERO));

  // Next scoreboard: clear on write first, then set on reserve so a new producer supersedes
  always_comb begin
    pending_d = pending_q;
    if (write_i) begin
      pending_d[waddr_i] = 1'b0;
    end
    if (reserve_i && !rsv_blocked) begin
      pending_d[rsv_addr_i] = 1'b1;
    end
  end

  // Scoreboard state register, cleared on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o     = pending_q;
  assign rd1_pending_o = pending_q[rd1_addr_i];
  assign rd2_pending_o = pending_q[rd2_addr_i];

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : reg_file_param                                         |
// | Parametrised CPU register file: one write port, two registered   |
// | read ports with valid flags, and a pending-write scoreboard.     |
// | Optional macro REGFILE_BYPASS_EN enables write-to-read           |
// | forwarding on the read ports.                                    |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module reg_file_param
  import cpu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int ZERO_REG0 = 0,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [DATA_W-1:0]   IN,
  input  logic [ADDR_W-1:0]   INADDRESS,
  input  logic                WRITE,
  input  logic [ADDR_W-1:0]   OUT1ADDRESS,
  input  logic [ADDR_W-1:0]   OUT2ADDRESS,
  output logic [DATA_W-1:0]   OUT1,
  output logic [DATA_W-1:0]   OUT2,
  output logic                OUT1VALID,
  output logic                OUT2VALID,
  input  logic                RESERVE,
  input  logic [ADDR_W-1:0]   RSVADDRESS,
  output logic [NUM_REGS-1:0] PENDING
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] out1_q, out1_d, out2_q, out2_d;
  logic              out1_vld_q, out1_vld_d, out2_vld_q, out2_vld_d;
  logic              rd1_pending, rd2_pending;
  logic              wr_zero, rd1_zero, rd2_zero;

  // Address-0 qualifiers; all constant-false when register 0 is an ordinary register
  assign wr_zero  = (ZERO_REG0 != 0) && (INADDRESS   == ADDR_W'(REG_ZERO));
  assign rd1_zero = (ZERO_REG0 != 0) && (OUT1ADDRESS == ADDR_W'(REG_ZERO));
  assign rd2_zero = (ZERO_REG0 != 0) && (OUT2ADDRESS == ADDR_W'(REG_ZERO));

  reg_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ZERO_REG0 (ZERO_REG0)
  ) u_scoreboard (
    .clk_i         (CLK),
    .rst_i         (RESET),
    .write_i       (WRITE),
    .waddr_i       (INADDRESS),
    .reserve_i     (RESERVE),
    .rsv_addr_i    (RSVADDRESS),
    .rd1_addr_i    (OUT1ADDRESS),
    .rd2_addr_i    (OUT2ADDRESS),
    .pending_o     (PENDING),
    .rd1_pending_o (rd1_pending),
    .rd2_pending_o (rd2_pending)
  );

  // Data array: cleared on reset, written unless the target is the hard-wired zero register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_W'(RESET_VAL);
      end
    end else if (WRITE && !wr_zero) begin
      regs_q[INADDRESS] <= IN;
    end
  end

  // Read-port next values: pre-edge contents, zero-register override, optional forwarding
  always_comb begin
    out1_d     = regs_q[OUT1ADDRESS];
    out1_vld_d = !rd1_pending;
    out2_d     = regs_q[OUT2ADDRESS];
    out2_vld_d = !rd2_pending;
    if (rd1_zero) begin
      out1_d     = DATA_W'(RESET_VAL);
      out1_vld_d = 1'b1;
    end
    if (rd2_zero) begin
      out2_d     = DATA_W'(RESET_VAL);
      out2_vld_d = 1'b1;
    end
`ifdef REGFILE_BYPASS_EN
    // Forward the write data; a same-edge reserve still marks the value as not final
    if (WRITE && (INADDRESS == OUT1ADDRESS) && !rd1_zero) begin
      out1_d     = IN;
      out1_vld_d = !(RESERVE && (RSVADDRESS == OUT1ADDRESS));
    end
    if (WRITE && (INADDRESS == OUT2ADDRESS) && !rd2_zero) begin
      out2_d     = IN;
      out2_vld_d = !(RESERVE && (RSVADDRESS == OUT2ADDRESS));
    end
`endif
  end

  // Read-port output registers; reset presents zero data marked valid
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out1_q     <= DATA_W'(RESET_VAL);
      out2_q     <= DATA_W'(RESET_VAL);
      out1_vld_q <= 1'b1;
      out2_vld_q <= 1'b1;
    end else begin
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      out1_vld_q <= out1_vld_d;
      out2_vld_q <= out2_vld_d;
    end
  end

  assign OUT1      = out1_q;
  assign OUT2      = out2_q;
  assign OUT1VALID = out1_vld_q;
  assign OUT2VALID = out2_vld_q;

endmodule : reg_file_param
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_reg_file_param                                      |
// | Scoreboard bench for reg_file_param: a default 8x8 instance and  |
// | a 32x32 instance with the zero register enabled. Expectations    |
// | follow REGFILE_BYPASS_EN when it is defined.                     |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_reg_file_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [31:0] o1;
    logic        v1;
    logic [31:0] o2;
    logic        v2;
    logic [31:0] pend;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 8 x 8-bit, ordinary register 0
  logic       a_rst = 1'b0, a_wr = 1'b0, a_rs = 1'b0;
  logic [7:0] a_in = '0, a_o1, a_o2, a_pend;
  logic [2:0] a_wa = '0, a_ra = '0, a_a1 = '0, a_a2 = '0;
  logic       a_v1, a_v2;

  reg_file_param #(.DATA_W(8), .NUM_REGS(8), .ZERO_REG0(0)) dut_a (
    .CLK(clk), .RESET(a_rst), .IN(a_in), .INADDRESS(a_wa), .WRITE(a_wr),
    .OUT1ADDRESS(a_a1), .OUT2ADDRESS(a_a2), .OUT1(a_o1), .OUT2(a_o2),
    .OUT1VALID(a_v1), .OUT2VALID(a_v2), .RESERVE(a_rs), .RSVADDRESS(a_ra),
    .PENDING(a_pend)
  );

  // Instance B: 32 x 32-bit, register 0 hard-wired to zero
  logic        b_rst = 1'b0, b_wr = 1'b0, b_rs = 1'b0;
  logic [31:0] b_in = '0, b_o1, b_o2, b_pend;
  logic [4:0]  b_wa = '0, b_ra = '0, b_a1 = '0, b_a2 = '0;
  logic        b_v1, b_v2;

  reg_file_param #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG0(1)) dut_b (
    .CLK(clk), .RESET(b_rst), .IN(b_in), .INADDRESS(b_wa), .WRITE(b_wr),
    .OUT1ADDRESS(b_a1), .OUT2ADDRESS(b_a2), .OUT1(b_o1), .OUT2(b_o2),
    .OUT1VALID(b_v1), .OUT2VALID(b_v2), .RESERVE(b_rs), .RSVADDRESS(b_ra),
    .PENDING(b_pend)
  );

  task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  // One cycle on instance A; the expected outputs after the coming edge are queued
  task automatic drv_a(input string nm, input logic rst, input logic wr, input logic [2:0] wa,
                       input logic [7:0] wd, input logic rs, input logic [2:0] ra,
                       input logic [2:0] a1, input logic [2:0] a2,
                       input logic [7:0] e1, input logic ev1, input logic [7:0] e2,
                       input logic ev2, input logic [7:0] ep);
    exp_t e;
    @(negedge clk);
    a_rst = rst; a_wr = wr; a_wa = wa; a_in = wd; a_rs = rs; a_ra = ra; a_a1 = a1; a_a2 = a2;
    e.nm = nm; e.o1 = 32'(e1); e.v1 = ev1; e.o2 = 32'(e2); e.v2 = ev2; e.pend = 32'(ep);
    qa.push_back(e);
  endtask

  task automatic drv_b(input string nm, input logic rst, input logic wr, input logic [4:0] wa,
                       input logic [31:0] wd, input logic rs, input logic [4:0] ra,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic ev1, input logic [31:0] e2,
                       input logic ev2, input logic [31:0] ep);
    exp_t e;
    @(negedge clk);
    b_rst = rst; b_wr = wr; b_wa = wa; b_in = wd; b_rs = rs; b_ra = ra; b_a1 = a1; b_a2 = a2;
    e.nm = nm; e.o1 = e1; e.v1 = ev1; e.o2 = e2; e.v2 = ev2; e.pend = ep;
    qb.push_back(e);
  endtask

  // Monitors: outputs are presented every edge; compare against the queued expectation
  initial begin : mon_a
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check({"A:", e.nm}, "OUT1",      32'(a_o1),   e.o1);
        check({"A:", e.nm}, "OUT1VALID", 32'(a_v1),   32'(e.v1));
        check({"A:", e.nm}, "OUT2",      32'(a_o2),   e.o2);
        check({"A:", e.nm}, "OUT2VALID", 32'(a_v2),   32'(e.v2));
        check({"A:", e.nm}, "PENDING",   32'(a_pend), e.pend);
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check({"B:", e.nm}, "OUT1",      b_o1,       e.o1);
        check({"B:", e.nm}, "OUT1VALID", 32'(b_v1),  32'(e.v1));
        check({"B:", e.nm}, "OUT2",      b_o2,       e.o2);
        check({"B:", e.nm}, "OUT2VALID", 32'(b_v2),  32'(e.v2));
        check({"B:", e.nm}, "PENDING",   b_pend,     e.pend);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    //     name         rst wr wa    wd     rs ra    a1    a2    e1                 ev1      e2                 ev2      pend
    drv_a("reset0",     1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd0, 8'h00,            1,       8'h00,             1,       8'h00);
    drv_a("wr1_rsv4",   0, 1, 3'd1, 8'h11, 1, 3'd4, 3'd0, 3'd0, 8'h00,            1,       8'h00,             1,       8'h10);
    drv_a("wr4_rd1_4",  0, 1, 3'd4, 8'h22, 0, 3'd0, 3'd1, 3'd4, 8'h11,            1,       BYP ? 8'h22 : 8'h00, BYP,   8'h00);
    drv_a("reset_mid",  1, 1, 3'd2, 8'h99, 1, 3'd6, 3'd1, 3'd4, 8'h00,            1,       8'h00,             1,       8'h00);
    drv_a("rd_cleared", 0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd1, 3'd4, 8'h00,            1,       8'h00,             1,       8'h00);
    drv_a("wr3_rd3",    0, 1, 3'd3, 8'h5A, 0, 3'd0, 3'd3, 3'd0, BYP ? 8'h5A : 8'h00, 1,    8'h00,             1,       8'h00);
    drv_a("rd3_both",   0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd3, 8'h5A,            1,       8'h5A,             1,       8'h00);
    drv_a("rsv5",       0, 0, 3'd0, 8'h00, 1, 3'd5, 3'd5, 3'd3, 8'h00,            1,       8'h5A,             1,       8'h20);
    drv_a("rd5_pend",   0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd5, 3'd5, 8'h00,            0,       8'h00,             0,       8'h20);
    drv_a("wr5",        0, 1, 3'd5, 8'hC3, 0, 3'd0, 3'd5, 3'd0, BYP ? 8'hC3 : 8'h00, BYP,  8'h00,             1,       8'h00);
    drv_a("rd5_done",   0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd5, 3'd0, 8'hC3,            1,       8'h00,             1,       8'h00);
    drv_a("wr2_rsv2",   0, 1, 3'd2, 8'hAB, 1, 3'd2, 3'd0, 3'd2, 8'h00,            1,       BYP ? 8'hAB : 8'h00, !BYP,  8'h04);
    drv_a("rd2_pend",   0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd2, 8'hAB,            0,       8'hAB,             0,       8'h04);
    drv_a("wr7_rsv1",   0, 1, 3'd7, 8'h44, 1, 3'd1, 3'd7, 3'd1, BYP ? 8'h44 : 8'h00, 1,    8'h00,             1,       8'h06);
    drv_a("rd7_rd1",    0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd7, 3'd1, 8'h44,            1,       8'h00,             0,       8'h06);
    drv_a("wr6_rd2_6",  0, 1, 3'd6, 8'h77, 0, 3'd0, 3'd7, 3'd6, 8'h44,            1,       BYP ? 8'h77 : 8'h00, 1,     8'h06);
    drv_a("rd6",        0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd6, 8'hAB,            0,       8'h77,             1,       8'h06);
    drv_a("wr2_clear",  0, 1, 3'd2, 8'h10, 0, 3'd0, 3'd2, 3'd1, BYP ? 8'h10 : 8'hAB, BYP,  8'h00,             0,       8'h02);
    drv_a("reset_end",  1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd1, 8'h00,            1,       8'h00,             1,       8'h00);
    @(negedge clk);
    a_rst = 1'b0;

    drv_b("reset0",     1, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0, 5'd0,  32'h0, 1, 32'h0, 1, 32'h0);
    drv_b("wr0_rsv0",   0, 1, 5'd0,  32'hDEADBEEF, 1, 5'd0,  5'd0, 5'd0,  32'h0, 1, 32'h0, 1, 32'h0);
    drv_b("wr31",       0, 1, 5'd31, 32'hDEADBEEF, 0, 5'd0,  5'd0, 5'd31, 32'h0, 1, BYP ? 32'hDEADBEEF : 32'h0, 1, 32'h0);
    drv_b("rd0_rd31",   0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0, 5'd31, 32'h0, 1, 32'hDEADBEEF, 1, 32'h0);
    drv_b("rsv31",      0, 0, 5'd0,  32'h0,        1, 5'd31, 5'd0, 5'd31, 32'h0, 1, 32'hDEADBEEF, 1, 32'h8000_0000);
    drv_b("rd31_pend",  0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0, 5'd31, 32'h0, 1, 32'hDEADBEEF, 0, 32'h8000_0000);
    drv_b("wr0_again",  0, 1, 5'd0,  32'h12345678, 1, 5'd0,  5'd0, 5'd31, 32'h0, 1, 32'hDEADBEEF, 0, 32'h8000_0000);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d/%0d entries left required=0/0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_reg_file_param
`default_nettype wire
